// File: rtl/mul_controller.sv
// Control FSM for a repeated-addition multiplier: fetches A then B, clears P, adds A into P
// until the B counter reaches zero, then pulses done. Optional abort support via MUL_ABORT_EN.
module mul_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_valid,
  input  logic             eqz,
`ifdef MUL_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             op_req,
  output logic             op_sel,
  output logic             lda,
  output logic             ldb,
  output logic             clrp,
  output logic             ldp,
  output logic             decb,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ADD    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state;
  logic   abort_hit;

`ifdef MUL_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Datapath strobes are Mealy so operands and additions land without an extra cycle of latency.
  always_comb begin
    lda  = 1'b0;
    ldb  = 1'b0;
    clrp = 1'b0;
    ldp  = 1'b0;
    decb = 1'b0;
    if (!abort_hit) begin
      case (state)
        LOAD_A: lda = op_valid;
        LOAD_B: begin
          ldb  = op_valid;
          clrp = op_valid;
        end
        ADD: begin
          ldp  = !eqz;
          decb = !eqz;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      iter_cnt <= '0;
      op_req   <= 1'b0;
      op_sel   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef MUL_ABORT_EN
      aborted  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MUL_ABORT_EN
      aborted <= abort_hit;
`endif
      if (abort_hit) begin
        state  <= IDLE;
        op_req <= 1'b0;
        op_sel <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= LOAD_A;
              iter_cnt <= '0;
              busy     <= 1'b1;
              op_req   <= 1'b1;
              op_sel   <= 1'b0;
            end
          end
          LOAD_A: begin
            if (op_valid) begin
              state  <= LOAD_B;
              op_sel <= 1'b1;
            end
          end
          LOAD_B: begin
            if (op_valid) begin
              state  <= ADD;
              op_req <= 1'b0;
              op_sel <= 1'b0;
            end
          end
          ADD: begin
            // The counter wraps naturally at 2^CNT_W.
            if (eqz) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              iter_cnt <= iter_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            op_req <= 1'b0;
            op_sel <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_controller.sv
// Directed bench for mul_controller with a behavioural A/B/P datapath around it.
// Abort scenarios are compiled in when MUL_ABORT_EN is defined.
module tb_mul_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_valid;
  logic        eqz;
  logic        op_req, op_sel, lda, ldb, clrp, ldp, decb, busy, done;
  logic [15:0] iter_cnt;
  logic [15:0] data_in;
`ifdef MUL_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  logic [15:0] a_reg = 16'd0;
  logic [15:0] b_reg = 16'd1;
  logic [15:0] p_reg = 16'd0;

  int vectors = 0;
  int miscompares = 0;

  int r_lda, r_ldb, r_first_ldp, r_done;
  int r_nlda, r_nldb, r_nclrp, r_nldp, r_ndecb, r_nreq, r_both;

  mul_controller #(.CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_valid (op_valid),
    .eqz      (eqz),
`ifdef MUL_ABORT_EN
    .abort    (abort),
    .aborted  (aborted),
`endif
    .op_req   (op_req),
    .op_sel   (op_sel),
    .lda      (lda),
    .ldb      (ldb),
    .clrp     (clrp),
    .ldp      (ldp),
    .decb     (decb),
    .busy     (busy),
    .done     (done),
    .iter_cnt (iter_cnt)
  );

  always #5 clk = ~clk;

  // Datapath model: reset does not touch it, only the strobes do.
  assign eqz = (b_reg == 16'd0);
  always @(posedge clk) begin
    if (lda) a_reg <= data_in;
    if (ldb) b_reg <= data_in;
    else if (decb) b_reg <= b_reg - 16'd1;
    if (clrp) p_reg <= 16'd0;
    else if (ldp) p_reg <= p_reg + a_reg;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one multiply; inputs change on negedge, outputs are sampled 1ns later.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input int hold_a, input int hold_b,
                               input bit poke_add, input bit poke_done, input int max_cyc);
    int cyc, wa, wb;
    r_lda = -1; r_ldb = -1; r_first_ldp = -1; r_done = -1;
    r_nlda = 0; r_nldb = 0; r_nclrp = 0; r_nldp = 0; r_ndecb = 0; r_nreq = 0; r_both = 0;
    wa = 0; wb = 0;
    @(negedge clk);
    start = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    cyc = 1;
    while (cyc <= max_cyc) begin
      start = 1'b0; op_valid = 1'b0; data_in = 16'h0;
      if (op_req && !op_sel) begin
        if (wa >= hold_a) begin op_valid = 1'b1; data_in = a; end
        else wa++;
      end else if (op_req && op_sel) begin
        if (wb >= hold_b) begin op_valid = 1'b1; data_in = b; end
        else wb++;
      end else begin
        op_valid = 1'b1; data_in = 16'hDEAD;
      end
      #1;
      if (op_req) r_nreq++;
      if (lda) begin r_lda = cyc; r_nlda++; end
      if (ldb) begin r_ldb = cyc; r_nldb++; end
      if (clrp) r_nclrp++;
      if (lda && ldb) r_both++;
      if (ldp) begin r_nldp++; if (r_first_ldp < 0) r_first_ldp = cyc; end
      if (decb) r_ndecb++;
      if (poke_add && ldp && r_nldp == 1) start = 1'b1;
      if (done) begin
        r_done = cyc;
        if (poke_done) start = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    op_valid = 1'b0;
    data_in = 16'h0;
  endtask

  task automatic idleCheck(input string tag);
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; op_valid = 1'b1; data_in = 16'h0;
`ifdef MUL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_flags", {23'd0, op_req, op_sel, lda, ldb, clrp, ldp, decb, busy, done}, 32'd0);
    checkOutput("rst_iter", {16'd0, iter_cnt}, 32'd0);
    rst = 1'b0; start = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_release_busy", {31'd0, busy}, 32'd0);

    // A=5, B=3, operands immediate, start poked during DONE
    applyStimulus(16'd5, 16'd3, 0, 0, 1'b0, 1'b1, 100);
    checkOutput("t2_lda_cyc", r_lda, 32'd1);
    checkOutput("t2_ldb_cyc", r_ldb, 32'd2);
    checkOutput("t2_first_ldp", r_first_ldp, 32'd3);
    checkOutput("t2_nldp", r_nldp, 32'd3);
    checkOutput("t2_ndecb", r_ndecb, 32'd3);
    checkOutput("t2_done_cyc", r_done, 32'd7);
    checkOutput("t2_nlda", r_nlda, 32'd1);
    checkOutput("t2_nclrp", r_nclrp, 32'd1);
    checkOutput("t2_p", {16'd0, p_reg}, 32'd15);
    checkOutput("t2_iter", {16'd0, iter_cnt}, 32'd3);
    idleCheck("t2");

    // B=0: no additions at all
    applyStimulus(16'd7, 16'd0, 0, 0, 1'b0, 1'b0, 100);
    checkOutput("t3_nldp", r_nldp, 32'd0);
    checkOutput("t3_ndecb", r_ndecb, 32'd0);
    checkOutput("t3_done_cyc", r_done, 32'd4);
    checkOutput("t3_p", {16'd0, p_reg}, 32'd0);
    checkOutput("t3_iter", {16'd0, iter_cnt}, 32'd0);

    // Withheld operands, start poked in ADD
    applyStimulus(16'd3, 16'd4, 3, 2, 1'b1, 1'b0, 100);
    checkOutput("t4_nreq", r_nreq, 32'd7);
    checkOutput("t4_lda_cyc", r_lda, 32'd4);
    checkOutput("t4_ldb_cyc", r_ldb, 32'd7);
    checkOutput("t4_nldb", r_nldb, 32'd1);
    checkOutput("t4_both", r_both, 32'd0);
    checkOutput("t4_done_cyc", r_done, 32'd13);
    checkOutput("t4_p", {16'd0, p_reg}, 32'd12);
    checkOutput("t4_iter", {16'd0, iter_cnt}, 32'd4);
    idleCheck("t4");

    // Maximum count, then an immediate back-to-back run
    applyStimulus(16'd1, 16'hFFFF, 0, 0, 1'b0, 1'b0, 70000);
    checkOutput("t5_done_cyc", r_done, 32'd65539);
    checkOutput("t5_nldp", r_nldp, 32'd65535);
    checkOutput("t5_p", {16'd0, p_reg}, 32'h0000FFFF);
    checkOutput("t5_iter", {16'd0, iter_cnt}, 32'h0000FFFF);
    applyStimulus(16'd2, 16'd3, 0, 0, 1'b0, 1'b0, 100);
    checkOutput("t5b_done_cyc", r_done, 32'd7);
    checkOutput("t5b_p", {16'd0, p_reg}, 32'd6);
    checkOutput("t5b_iter", {16'd0, iter_cnt}, 32'd3);
    idleCheck("t5b");

`ifdef MUL_ABORT_EN
    // Abort after two additions with A=4, B=9
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; op_valid = 1'b1; data_in = 16'd4;
    @(negedge clk); data_in = 16'd9;
    @(negedge clk); op_valid = 1'b0; data_in = 16'h0;
    @(negedge clk);
    @(negedge clk); abort = 1'b1;
    #1;
    checkOutput("t6_abort_strobes", {30'd0, ldp, decb}, 32'd0);
    checkOutput("t6_abort_done", {31'd0, done}, 32'd0);
    @(negedge clk); abort = 1'b0;
    #1;
    checkOutput("t6_aborted", {31'd0, aborted}, 32'd1);
    checkOutput("t6_busy", {30'd0, busy, done}, 32'd0);
    checkOutput("t6_iter", {16'd0, iter_cnt}, 32'd2);
    checkOutput("t6_p", {16'd0, p_reg}, 32'd8);
    @(negedge clk);
    #1;
    checkOutput("t6_aborted_pulse", {31'd0, aborted}, 32'd0);
`endif

    // Reset while waiting in LOAD_B
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; op_valid = 1'b1; data_in = 16'd6;
    @(negedge clk); op_valid = 1'b0; data_in = 16'h0; rst = 1'b1;
    #1;
    checkOutput("t7_loadb_req", {30'd0, op_req, op_sel}, 32'd3);
    @(negedge clk); rst = 1'b0;
    #1;
    checkOutput("t7_rst_flags", {23'd0, op_req, op_sel, lda, ldb, clrp, ldp, decb, busy, done}, 32'd0);
    checkOutput("t7_rst_iter", {16'd0, iter_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
